jtag_word_loader: RTL

Parametrised JTAG-to-memory loader between the `jtag` receiver and a program/data memory such as `hippo_memory`. It synchronises the receiver's asynchronous 4-phase byte handshake and packs `WORD_BYTES` bytes little-endian into one memory word. It writes each word with byte enables at an auto-incrementing address and flushes a partial word when the session ends. It also reports word count, busy, and overflow/wrap status.

---
 rtl/jtag_word_loader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/jtag_word_loader.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | jtag_word_loader : packs JTAG 4-phase handshake bytes into memory words.  |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module jtag_word_loader #(
    parameter int BYTE_W      = 8,
    parameter int WORD_BYTES  = 4,
    parameter int ADDR_W      = 10,
    parameter int SYNC_STAGES = 2,
    parameter int WRAP        = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         sel_i,
    input  logic                         word_rdy_i,
    input  logic [BYTE_W-1:0]            data_i,
    output logic                         ack_o,
    output logic                         mem_we_o,
    output logic [ADDR_W-1:0]            mem_addr_o,
    output logic [BYTE_W*WORD_BYTES-1:0] mem_data_o,
    output logic [WORD_BYTES-1:0]        mem_be_o,
    output logic [ADDR_W:0]              words_o,
    output logic                         busy_o,
    output logic                         overflow_o
);

    localparam int WORD_W = BYTE_W * WORD_BYTES;
    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_WAIT_LOW = 3'd2,
        S_WRITE    = 3'd3,
        S_FLUSH    = 3'd4,
        S_FULL     = 3'd5
    } state_e;

    state_e                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sel_sync_q, sel_sync_d;
    logic [SYNC_STAGES-1:0]   rdy_sync_q, rdy_sync_d;
    logic [LANE_W-1:0]        lane_q, lane_d;
    logic [WORD_W-1:0]        word_q, word_d;
    logic [WORD_BYTES-1:0]    valid_q, valid_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [ADDR_W:0]          words_q, words_d;
    logic                     ack_q, ack_d;
    logic                     ovf_q, ovf_d;
    logic                     sel_s, rdy_s;

    assign sel_s = sel_sync_q[SYNC_STAGES-1];
    assign rdy_s = rdy_sync_q[SYNC_STAGES-1];

    always_comb begin
        sel_sync_d = {sel_sync_q[SYNC_STAGES-2:0], sel_i};
        rdy_sync_d = {rdy_sync_q[SYNC_STAGES-2:0], word_rdy_i};
        state_d    = state_q;
        lane_d     = lane_q;
        word_d     = word_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        words_d    = words_q;
        ack_d      = ack_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                ack_d = 1'b0;
                if (sel_s) begin
                    addr_d  = '0;
                    lane_d  = '0;
                    word_d  = '0;
                    valid_d = '0;
                    words_d = '0;
                    ovf_d   = 1'b0;
                    state_d = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                // Session end wins over a byte arriving in the same cycle.
                if (!sel_s) begin
                    state_d = (|valid_q) ? S_FLUSH : S_IDLE;
                end else if (rdy_s) begin
                    word_d[int'(lane_q)*BYTE_W +: BYTE_W] = data_i;
                    valid_d[lane_q] = 1'b1;
                    ack_d   = 1'b1;
                    state_d = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (!sel_s) begin
                    ack_d   = 1'b0;
                    state_d = S_FLUSH;
                end else if (!rdy_s) begin
                    ack_d = 1'b0;
                    if (lane_q == LAST_LANE) begin
                        state_d = S_WRITE;
                    end else begin
                        lane_d  = lane_q + LANE_W'(1);
                        state_d = S_WAIT_RDY;
                    end
                end
            end
            S_WRITE, S_FLUSH: begin
                word_d  = '0;
                valid_d = '0;
                lane_d  = '0;
                addr_d  = addr_q + ADDR_W'(1);
                if (words_q != DEPTH_CNT) begin
                    words_d = words_q + (ADDR_W + 1)'(1);
                end
                state_d = (state_q == S_WRITE) ? S_WAIT_RDY : S_IDLE;
                if (&addr_q) begin
                    if (WRAP == 0) begin
                        state_d = S_FULL;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            S_FULL: begin
                // Keep acknowledging so the JTAG side never stalls; bytes are dropped.
                ack_d = rdy_s;
                if (rdy_s) begin
                    ovf_d = 1'b1;
                end
                if (!sel_s) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            sel_sync_q <= '0;
            rdy_sync_q <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            valid_q    <= '0;
            addr_q     <= '0;
            words_q    <= '0;
            ack_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_sync_q <= sel_sync_d;
            rdy_sync_q <= rdy_sync_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
            ack_q      <= ack_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ack_o      = ack_q;
    assign mem_we_o   = (state_q == S_WRITE) || (state_q == S_FLUSH);
    assign mem_addr_o = addr_q;
    assign mem_data_o = word_q;
    assign mem_be_o   = valid_q;
    assign words_o    = words_q;
    assign busy_o     = (state_q != S_IDLE);
    assign overflow_o = ovf_q;

endmodule
`default_nettype wire
